dice_display: RTL



---
 rtl/dice_display.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dice_display.sv
// Display side of the electronic dice: blinks the pips while rolling, then qualifies and shows the settled throw.
// Optional `define DICE_DOUBLES_EN adds a registered `doubles` flag (same value as the previous accepted result).
module dice_display #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLINK_DIV     = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  output logic [6:0]       pips,
  output logic [2:0]       result,
  output logic             result_valid,
  output logic             new_result,
  output logic [CNT_W-1:0] roll_count,
`ifdef DICE_DOUBLES_EN
  output logic             doubles,
`endif
  output logic             error
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ROLLING, SETTLING, SHOW} state_e;

  state_e           state_q, state_d;
  logic [6:0]       pips_q, pips_d;
  logic [2:0]       result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             new_result_q, new_result_d;
  logic [CNT_W-1:0] roll_count_q, roll_count_d;
  logic             error_q, error_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [2:0]       prev_q, prev_d;
  logic             doubles_q, doubles_d;

  function automatic logic [6:0] pip_decode(input logic [2:0] v);
    case (v)
      3'd1:    pip_decode = 7'h01;
      3'd2:    pip_decode = 7'h42;
      3'd3:    pip_decode = 7'h43;
      3'd4:    pip_decode = 7'h66;
      3'd5:    pip_decode = 7'h67;
      3'd6:    pip_decode = 7'h7E;
      default: pip_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every *_d gets a default here so no path through the case infers a latch.
    state_d        = state_q;
    pips_d         = pips_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    new_result_d   = 1'b0;
    roll_count_d   = roll_count_q;
    error_d        = error_q;
    blink_cnt_d    = blink_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    prev_d         = prev_q;
    doubles_d      = doubles_q;

    // A press from any state restarts the roll with all pips lit.
    if (button && state_q != ROLLING) begin
      state_d        = ROLLING;
      pips_d         = 7'h7F;
      blink_cnt_d    = '0;
      result_valid_d = 1'b0;
      doubles_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: pips_d = 7'h00;
        ROLLING: begin
          if (!button) begin
            state_d      = SETTLING;
            pips_d       = 7'h00;
            prev_d       = throw;
            settle_cnt_d = SW'(1);
          end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            pips_d      = ~pips_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        SETTLING: begin
          // Enough equal samples collected: qualify the held value, ignoring this edge's sample.
          if (settle_cnt_q == SW'(SETTLE_CYCLES)) begin
            if (prev_q != 3'd0 && prev_q != 3'd7) begin
              state_d        = SHOW;
              result_d       = prev_q;
              result_valid_d = 1'b1;
              new_result_d   = 1'b1;
              error_d        = 1'b0;
              pips_d         = pip_decode(prev_q);
              doubles_d      = (roll_count_q != '0) && (prev_q == result_q);
              if (roll_count_q != '1) roll_count_d = roll_count_q + CNT_W'(1);
            end else begin
              state_d = IDLE;
              error_d = 1'b1;
            end
          end else if (throw == prev_q) begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end else begin
            prev_d       = throw;
            settle_cnt_d = SW'(1);
          end
        end
        SHOW: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pips_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      new_result_q   <= 1'b0;
      roll_count_q   <= '0;
      error_q        <= 1'b0;
      blink_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      prev_q         <= '0;
      doubles_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q        <= state_d;
      pips_q         <= pips_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      new_result_q   <= new_result_d;
      roll_count_q   <= roll_count_d;
      error_q        <= error_d;
      blink_cnt_q    <= blink_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      prev_q         <= prev_d;
      doubles_q      <= doubles_d;
    end
  end

  assign pips         = pips_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign new_result   = new_result_q;
  assign roll_count   = roll_count_q;
  assign error        = error_q;
`ifdef DICE_DOUBLES_EN
  assign doubles      = doubles_q;
`else
  logic unused_doubles;
  assign unused_doubles = doubles_q;
`endif

endmodule
